// File: rtl/hs_master_fifo.sv
// ---------------------------------------------------------------------------
// hs_master_fifo
//   Upstream source stage for a valid/ready slave. Producer words are
//   buffered in a DEPTH-entry FIFO. When words are waiting, the block raises
//   ren towards the slave. Once the slave answers with ready, the block
//   streams the buffered words at up to one word per cycle.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous, active-low reset
//   wr_en     : producer push strobe
//   wr_data   : producer word
//   full      : FIFO holds DEPTH words; pushes are refused
//   overflow  : sticky flag, set when a push is attempted while full
//   count     : words currently buffered (0..DEPTH)
//   ren       : request to the slave (registered)
//   valid     : data_out carries a word to transfer (registered)
//   ready     : slave accept; a transfer occurs on an edge with valid && ready
//   data_out  : FIFO head word, forced to 0 while empty
//   tx_count  : completed transfers, wraps modulo 2^CW
// ---------------------------------------------------------------------------
module hs_master_fifo #(
  parameter int L     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [L-1:0]  wr_data,
  output logic          full,
  output logic          overflow,
  output logic [AW:0]   count,
  output logic          ren,
  output logic          valid,
  input  logic          ready,
  output logic [L-1:0]  data_out,
  output logic [CW-1:0] tx_count
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t        state;
  logic [L-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign push     = wr_en && !full;
  assign pop      = valid && ready;
  assign data_out = (count == '0) ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; it is only observable through
  // data_out, which is masked to 0 while count==0, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO bookkeeping. The pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  // NOTE: all sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        tx_count <= tx_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A refused push stays recorded even if a pop frees a slot on the same edge.
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Handshake sequencer with registered ren/valid. IDLE checks the registered
  // count, so a push seen on one edge raises ren on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ren   <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= REQ;
            ren   <= 1'b1;
          end
        end
        REQ: begin
          if (ready) begin
            state <= XFER;
            valid <= 1'b1;
          end
        end
        XFER: begin
          // Leave XFER only when the final buffered word is popped and no replacement arrives.
          if (pop && (count == (AW+1)'(1)) && !push) begin
            state <= IDLE;
            ren   <= 1'b0;
            valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ren   <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_master_fifo.sv
module tb_hs_master_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        full;
  logic        overflow;
  logic [2:0]  count;
  logic        ren;
  logic        valid;
  logic        ready;
  logic [7:0]  data_out;
  logic [15:0] tx_count;

  // Slave model: ready follows ren one cycle later; hold forces it low.
  logic ready_d;
  logic hold = 1'b0;
  assign ready = ready_d && !hold;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [7:0] rx[$];
  int         rx_cyc[$];

  hs_master_fifo #(.L(8), .DEPTH(4), .AW(2), .CW(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .overflow(overflow), .count(count), .ren(ren), .valid(valid),
    .ready(ready), .data_out(data_out), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) ready_d <= 1'b0;
    else      ready_d <= ren;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // A transfer will occur on the next rising edge when valid && ready are high mid-cycle.
  always @(negedge clk) begin
    if (rst && valid && ready) begin
      rx.push_back(data_out);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 12; k++) begin
      if (valid) break;
      tick();
    end
    check(tag, valid, 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 30; k++) begin
      if (count == 0 && !valid) break;
      tick();
    end
    check(tag, {count, valid}, 0);
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ren", ren, 0);
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tx", tx_count, 0);
    check("rst_data", data_out, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1. Single word latency
    push(8'hA5);
    check("t1_count_n", count, 1);
    check("t1_ren_n", ren, 0);
    tick();
    check("t1_ren_n1", ren, 1);
    check("t1_valid_n1", valid, 0);
    tick();
    check("t1_valid_n2", valid, 0);
    tick();
    check("t1_valid_n3", valid, 1);
    check("t1_data_n3", data_out, 8'hA5);
    tick();
    check("t1_valid_n4", valid, 0);
    check("t1_ren_n4", ren, 0);
    check("t1_count_n4", count, 0);
    check("t1_tx", tx_count, 1);
    check("t1_rx_n", rx.size(), 1);
    check("t1_rx0", rx[0], 8'hA5);
    tick();
    tick();

    // 2. Burst of four, back-to-back pushes
    rx.delete();
    rx_cyc.delete();
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("t2_full", full, 1);
    check("t2_count", count, 4);
    check("t2_ovf", overflow, 0);
    wait_drain("t2_drain");
    check("t2_rx_n", rx.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_rx%0d", i), rx[i], i + 1);
    for (int i = 0; i < 3; i++) check($sformatf("t2_gap%0d", i), rx_cyc[i+1] - rx_cyc[i], 1);
    check("t2_tx", tx_count, 5);

    // 3. Backpressure while valid
    rx.delete();
    push(8'h3C);
    push(8'h5A);
    wait_valid("t3_valid_up");
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_valid_h%0d", i), valid, 1);
      check($sformatf("t3_data_h%0d", i), data_out, 8'h3C);
      check($sformatf("t3_count_h%0d", i), count, 2);
    end
    check("t3_rx_held", rx.size(), 0);
    hold = 1'b0;
    wait_drain("t3_drain");
    check("t3_rx_n", rx.size(), 2);
    check("t3_rx0", rx[0], 8'h3C);
    check("t3_rx1", rx[1], 8'h5A);
    check("t3_tx", tx_count, 7);

    // 4. Overflow: fifth push with the slave stalled is dropped
    rx.delete();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    check("t4_ovf_pre", overflow, 0);
    push(8'hFF);
    check("t4_ovf", overflow, 1);
    check("t4_count", count, 4);
    check("t4_full", full, 1);
    check("t4_head", data_out, 8'h10);
    hold = 1'b0;
    wait_drain("t4_drain");
    check("t4_rx_n", rx.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t4_rx%0d", i), rx[i], 8'h10 + i);
    check("t4_ovf_sticky", overflow, 1);
    check("t4_tx", tx_count, 11);

    // 5. Simultaneous push and pop with a single word in XFER
    rx.delete();
    push(8'h77);
    wait_valid("t5_valid_up");
    check("t5_count1", count, 1);
    push(8'h88);
    check("t5_count_pp", count, 1);
    check("t5_valid_pp", valid, 1);
    check("t5_data_pp", data_out, 8'h88);
    tick();
    check("t5_valid_end", valid, 0);
    check("t5_count_end", count, 0);
    check("t5_rx_n", rx.size(), 2);
    check("t5_rx0", rx[0], 8'h77);
    check("t5_rx1", rx[1], 8'h88);
    check("t5_tx", tx_count, 13);
    tick();
    tick();

    // 6. Asynchronous reset mid-burst
    rx.delete();
    push(8'h21);
    push(8'h22);
    push(8'h23);
    wait_valid("t6_valid_up");
    hold = 1'b1;
    check("t6_count3", count, 3);
    check("t6_ren_pre", ren, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_ren_rst", ren, 0);
    check("t6_valid_rst", valid, 0);
    check("t6_count_rst", count, 0);
    check("t6_tx_rst", tx_count, 0);
    check("t6_ovf_rst", overflow, 0);
    check("t6_data_rst", data_out, 0);
    @(negedge clk);
    rst  = 1'b1;
    hold = 1'b0;
    rx.delete();
    push(8'hAB);
    check("t6_ren_n", ren, 0);
    check("t6_count_n", count, 1);
    tick();
    check("t6_ren_n1", ren, 1);
    wait_valid("t6_valid_up2");
    check("t6_data", data_out, 8'hAB);
    wait_drain("t6_drain");
    check("t6_tx", tx_count, 1);
    check("t6_rx_n", rx.size(), 1);
    check("t6_rx0", rx[0], 8'hAB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
